// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM encoding, data width, ID width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    DONE       = 3'd4
  } arb_state_t;

  // Width of a requester index; never below 1 bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible request at or after ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] elig;
  logic [N-1:0] rot;
  logic [IW:0]  sum;

  assign elig = req & mask;
  // Rotate so bit 0 is the requester at the pointer.
  assign rot  = N'({elig, elig} >> ptr);

  always_comb begin
    found = 1'b0;
    sum   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(j);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      end
    end
    idx   = sum[IW-1:0];
    grant = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers: per-byte round-robin with an
// optional owner lock, a lock idle timeout, and a start-handshake watchdog.
//
// state      | meaning
// IDLE       | arbitrate; lock drop / idle-timeout handling
// ISSUE      | tx_data_valid pulse for the captured byte
// WAIT_START | waiting up to START_WAIT cycles for tx_busy to rise
// WAIT_DONE  | frame in progress, waiting for tx_busy to fall
// DONE       | decide whether the owner keeps the lock
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int LOCK_TIMEOUT = 1024,
  parameter  int START_WAIT   = 3,
  localparam int IDW          = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_DATA_W-1:0]         tx_data,
  output logic                           tx_data_valid,
  input  logic                           tx_busy,
  output logic [IDW-1:0]                 grant_id,
  output logic                           lock_active,
  output logic                           lock_timeout,
  output logic                           start_err
);

  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SW = $clog2(START_WAIT) + 1;
  localparam logic [TW-1:0]  TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0]  SW_LAST  = SW'(START_WAIT - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  arb_state_t           state;
  logic [IDW-1:0]       ptr;
  logic [TW-1:0]        to_cnt;
  logic [SW-1:0]        sw_cnt;

  logic                 owner_lock_req;
  logic                 owner_valid;
  logic                 lock_held;
  logic [NUM_REQ-1:0]   elig_mask;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [IDW-1:0]       win_idx;
  logic                 win_found;
  logic                 accept;
  logic [UART_DATA_W-1:0] win_data;

  assign owner_lock_req = req_lock[grant_id];
  assign owner_valid    = req_valid[grant_id];
  // Lock only counts while the owner still asks for it; a drop reopens RR at once.
  assign lock_held      = lock_active && owner_lock_req;
  assign elig_mask      = lock_held ? (NUM_REQ'(1) << grant_id) : '1;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .mask  (elig_mask),
    .ptr   (ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .found (win_found)
  );

  assign accept    = reset && (state == IDLE) && !tx_busy && win_found;
  assign req_ready = accept ? win_onehot : '0;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) win_data = req_data[UART_DATA_W*i +: UART_DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_id      <= '0;
      lock_active   <= 1'b0;
      to_cnt        <= '0;
      sw_cnt        <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      lock_timeout  <= 1'b0;
      start_err     <= 1'b0;
    end else begin
      tx_data_valid <= 1'b0;
      lock_timeout  <= 1'b0;
      start_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (lock_active && !owner_lock_req) lock_active <= 1'b0;
          if (accept) begin
            tx_data       <= win_data;
            grant_id      <= win_idx;
            ptr           <= (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
            to_cnt        <= '0;
            tx_data_valid <= 1'b1;
            state         <= ISSUE;
          end else if (lock_held && !owner_valid) begin
            if (to_cnt == TO_LAST) begin
              lock_timeout <= 1'b1;
              lock_active  <= 1'b0;
              to_cnt       <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          sw_cnt <= '0;
          state  <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (sw_cnt == SW_LAST) begin
            start_err <= 1'b1;
            state     <= DONE;
          end else begin
            sw_cnt <= sw_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= DONE;
        end
        DONE: begin
          if (owner_lock_req) begin
            lock_active <= 1'b1;
            to_cnt      <= '0;
          end else begin
            lock_active <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a timeline reference model and a uart_tx stand-in.
module tb_uart_tx_arbiter;

  localparam int N     = 3;
  localparam int LT    = 8;
  localparam int SWAIT = 3;
  localparam int IDW   = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_data_valid;
  logic           tx_busy = 1'b0;
  logic [IDW-1:0] grant_id;
  logic           lock_active;
  logic           lock_timeout;
  logic           start_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT), .START_WAIT(SWAIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_lock      (req_lock),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_busy       (tx_busy),
    .grant_id      (grant_id),
    .lock_active   (lock_active),
    .lock_timeout  (lock_timeout),
    .start_err     (start_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- producers ----------------
  typedef struct { logic [7:0] d; bit l; } item_t;
  item_t pq [N][$];
  bit    last_lock [N];
  bit    rel [N];
  bit    acc [N];

  task automatic push(input int i, input logic [7:0] d, input bit l);
    item_t it;
    it.d = d;
    it.l = l;
    pq[i].push_back(it);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) acc[i] = req_valid[i] && req_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          last_lock[i] = pq[i][0].l;
          void'(pq[i].pop_front());
        end
        if (rel[i]) begin
          last_lock[i] = 1'b0;
          rel[i] = 1'b0;
        end
        if (pq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = pq[i][0].d;
          req_lock[i]        = pq[i][0].l;
        end else begin
          req_valid[i] = 1'b0;
          req_lock[i]  = last_lock[i];
        end
      end
    end
  end

  // ---------------- uart_tx stand-in ----------------
  int busy_len = 10;
  bit rand_busy = 1'b0;
  bit no_start = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_data_valid === 1'b1 && !no_start) begin
        int len;
        len = rand_busy ? int'($urandom_range(1, 6)) : busy_len;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic [7:0] d; int id; } exp_t;
  exp_t sb[$];

  bit       m_free = 1'b1;
  bit       m_lock = 1'b0;
  bit       m_started = 1'b0;
  int       m_owner = 0;
  int       m_ptr = 0;
  int       m_cnt = 0;
  int       m_pulse = -10;
  int       m_finish = -1;
  int       exp_to = -1;
  int       exp_se = -1;
  logic [7:0] m_data = '0;

  initial begin
    int c;
    int w;
    int j;
    bit held;
    logic [N-1:0] exp_ready;
    exp_t e;
    forever begin
      @(negedge clk);
      c = cyc;
      check("tx_data_valid", int'(tx_data_valid), (c == m_pulse) ? 1 : 0);
      check("lock_timeout", int'(lock_timeout), (c == exp_to) ? 1 : 0);
      check("start_err", int'(start_err), (c == exp_se) ? 1 : 0);
      check("lock_active", int'(lock_active), int'(m_lock));
      check("grant_id", int'(grant_id), m_owner);
      check("tx_data", int'(tx_data), int'(m_data));

      held = m_lock && req_lock[m_owner];
      w = -1;
      if (reset && m_free && !tx_busy) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && req_valid[j] && (!held || j == m_owner)) w = j;
        end
      end
      exp_ready = (w >= 0) ? N'(1 << w) : '0;
      check("req_ready", int'(req_ready), int'(exp_ready));

      if (!reset) begin
        m_free = 1'b1; m_lock = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_data = '0; m_pulse = -10; m_finish = -1; exp_to = -1; exp_se = -1;
      end else if (m_free) begin
        if (m_lock && !req_lock[m_owner]) m_lock = 1'b0;
        if (w >= 0) begin
          e.cyc = c + 1;
          e.d   = req_data[8*w +: 8];
          e.id  = w;
          sb.push_back(e);
          m_data    = req_data[8*w +: 8];
          m_owner   = w;
          m_ptr     = (w + 1) % N;
          m_cnt     = 0;
          m_free    = 1'b0;
          m_pulse   = c + 1;
          m_started = 1'b0;
          m_finish  = -1;
        end else if (held && !req_valid[m_owner]) begin
          if (m_cnt == LT - 1) begin
            m_lock = 1'b0;
            m_cnt  = 0;
            exp_to = c + 1;
          end else begin
            m_cnt++;
          end
        end
      end else begin
        if (c == m_finish) begin
          m_lock = req_lock[m_owner];
          if (m_lock) m_cnt = 0;
          m_free = 1'b1;
        end else if (c > m_pulse && m_finish < 0) begin
          if (!m_started) begin
            if (tx_busy) m_started = 1'b1;
            else if (c - m_pulse == SWAIT) begin
              exp_se   = c + 1;
              m_finish = c + 1;
            end
          end else if (!tx_busy) begin
            m_finish = c + 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_data_valid === 1'b1) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: pulse with tx_data 0x%0h, expected no pulse (cycle %0d)", tx_data, cyc);
        end else begin
          e = sb.pop_front();
          check("sb_cycle", cyc, e.cyc);
          check("sb_data", int'(tx_data), int'(e.d));
          check("sb_grant", int'(grant_id), e.id);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit producers_empty();
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b0;
    return req_valid == '0;
  endfunction

  // mode 0: everything drained; 1: requester 1 empty and arbiter idle; 2: tx_busy high
  task automatic wait_for(input int mode, input int budget);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      case (mode)
        0: ok = producers_empty() && m_free && !tx_busy;
        1: ok = (pq[1].size() == 0) && m_free && !tx_busy;
        default: ok = tx_busy;
      endcase
    end
    check($sformatf("wait_mode%0d_timeout", mode), int'(ok), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single byte
    busy_len = 10;
    push(0, 8'h41, 1'b0);
    wait_for(0, 500);

    // round robin with two continuous producers
    for (int k = 0; k < 2; k++) begin
      push(0, 8'hA0, 1'b0);
      push(1, 8'hB1, 1'b0);
    end
    wait_for(0, 500);

    // locked message from req1 while req0 waits
    busy_len = 4;
    push(1, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    push(1, 8'h12, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    push(0, 8'h55, 1'b0);
    wait_for(1, 500);
    repeat (3) @(posedge clk);
    #1 rel[1] = 1'b1;
    wait_for(0, 500);

    // stale lock broken by timeout
    push(1, 8'h20, 1'b1);
    wait_for(1, 500);
    push(0, 8'h30, 1'b0);
    wait_for(0, 500);
    rel[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // start handshake never seen
    no_start = 1'b1;
    push(2, 8'h77, 1'b0);
    wait_for(0, 500);
    no_start = 1'b0;
    push(2, 8'h78, 1'b0);
    wait_for(0, 500);

    // reset while a frame is in progress
    busy_len = 12;
    push(0, 8'h99, 1'b0);
    wait_for(2, 100);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push(1, 8'h5A, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_for(0, 500);

    // randomized traffic
    rand_busy = 1'b1;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 2) == 0 && pq[r].size() < 3)
        push(r, 8'($urandom()), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 15) == 0) rel[$urandom_range(0, N - 1)] = 1'b1;
      no_start = ($urandom_range(0, 11) == 0);
      @(posedge clk);
      #1;
    end
    no_start = 1'b0;
    wait_for(0, 3000);
    for (int i = 0; i < N; i++) rel[i] = 1'b1;
    repeat (LT + 4) @(posedge clk);
    #1;

    while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
    check("sb_leftover", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(60000 * 10);
    errors++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx transmitter between NUM_REQ byte producers, e.g. CPU MMIO TX register (req 0) and a boot/debug monitor (req 1).
- Round-robin grant per byte, with an optional lock so one requester can send an uninterrupted multi-byte message. A timeout breaks a stale lock.
- Sits between the producers and uart_tx. It drives tx_data/tx_data_valid and sequences each byte off tx_busy.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- LOCK_TIMEOUT, 1024: idle cycles a locked owner may hold the grant without presenting a byte.
- START_WAIT, 3: max cycles after the tx_data_valid pulse to see tx_busy rise.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_lock  in  NUM_REQ  requester i wants to keep the grant after the current byte
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle (valid&ready = transfer)
- tx_data  out  8  byte to uart_tx
- tx_data_valid  out  1  one-cycle start pulse to uart_tx
- tx_busy  in  1  uart_tx transmitting
- grant_id  out  clog2(NUM_REQ)  current or last owner
- lock_active  out  1  a lock is held
- lock_timeout  out  1  one-cycle pulse when a lock is force-released
- start_err  out  1  one-cycle pulse when tx_busy failed to rise within START_WAIT

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; all outputs 0.
  - RR pointer = 0, lock cleared, timeout counter = 0.
  - Any in-flight byte is abandoned, with no further tx_data_valid.
- IDLE state:
  - req_ready[i] is combinational: 1 only for the selected winner, when req_valid[winner]=1 and tx_busy=0. At most one bit is high.
  - Unlocked: the winner is the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - Locked: only the owner is eligible; all other req_ready are 0.
  - On transfer: capture req_data into tx_data, set grant_id = winner, go to ISSUE. Pointer = winner+1 mod NUM_REQ, wrapping at NUM_REQ-1.
- ISSUE state: tx_data_valid=1 for exactly this cycle; go to WAIT_START.
- WAIT_START state:
  - When tx_busy=1, go to WAIT_DONE.
  - If START_WAIT cycles pass without tx_busy, pulse start_err and go to DONE.
- WAIT_DONE state: when tx_busy=0, go to DONE.
- DONE state (1 cycle):
  - If req_lock[grant_id]=1: lock_active=1, owner retained, timeout counter cleared.
  - Otherwise: lock_active=0.
  - Go to IDLE.
- Throughput and latency:
  - One byte per transfer.
  - Transfer-to-tx_data_valid latency is exactly 1 cycle.
  - tx_data is held stable from ISSUE until the next transfer.
- Lock release:
  - The owner drops req_lock while in IDLE → lock cleared that cycle; normal RR resumes the same cycle.
  - In IDLE with the lock held and req_valid[owner]=0, the counter increments each cycle. At LOCK_TIMEOUT-1 it pulses lock_timeout, clears the lock, and resets the counter.
  - Counter resets on every owner transfer.
- Simultaneous events:
  - Several valid at once: strict RR from the pointer.
  - req_lock asserted by a non-owner: ignored until that requester wins.
  - Owner transfer in the same cycle as the timeout threshold: the transfer wins and there is no timeout pulse.
- tx_busy already 1 in IDLE (e.g. after reset mid-frame): no req_ready until it drops.
- Requesters must hold req_valid/req_data stable until ready; the block does not check this.

Decomposition:
- Package uart_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE), 3 bits;
  - UART_DATA_W=8;
  - the ID width function.
- One natural sub-module: rr_arbiter. It is a combinational round-robin pick given a request vector, pointer and lock mask, and returns a one-hot grant plus an index.
- The FSM, lock and counters live in uart_tx_arbiter.

Test Plan:
- Single byte: req0 valid with 0x41, tx_busy rises 1 cycle after the pulse and lasts 10 cycles.
  - req_ready[0] for 1 cycle, then tx_data_valid next cycle with tx_data=0x41.
  - Next acceptance no earlier than DONE+1.
- Round-robin: req0 and req1 both valid continuously (0xA0, 0xB1).
  - Accepted order 0,1,0,1; grant_id alternates; no starvation.
- Lock: req1 sends 0x10,0x11,0x12 with req_lock=1 while req0 is valid.
  - All three of req1's bytes go out back-to-back; req_ready[0]=0 throughout.
  - req0 is served after req1 drops req_lock.
- Lock timeout: LOCK_TIMEOUT=8, req1 locks then goes idle, req0 valid.
  - lock_timeout pulses after 8 idle cycles, then req0 is accepted the following cycle.
- start_err: tx_busy held 0 after the pulse.
  - start_err after START_WAIT cycles; FSM returns to IDLE; the next byte is accepted.
- Reset mid-frame: reset low during WAIT_DONE.
  - All outputs 0 next cycle; no tx_data_valid afterwards; req_ready stays 0 while tx_busy=1.
